// File: rtl/pmod_led_scheduler_pkg.sv
// Shared IAGC status codes, LED colours and event-player types for the PMOD LED scheduler.
package pmod_pkg;

    localparam int IAGC_STATUS_INIT      = 1;
    localparam int IAGC_STATUS_IDLE      = 2;
    localparam int IAGC_STATUS_SAMPLE    = 3;
    localparam int IAGC_STATUS_CMD_ERROR = 6;
    localparam int IAGC_STATUS_DUMP_MEM  = 7;
    localparam int IAGC_STATUS_HALT      = 11;

    localparam logic [2:0] COLOR_OFF     = 3'b000;
    localparam logic [2:0] COLOR_RED     = 3'b100;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_BLUE    = 3'b001;
    localparam logic [2:0] COLOR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;

    typedef enum logic [1:0] {
        PLAYER_IDLE = 2'd0,
        PLAYER_LOAD = 2'd1,
        PLAYER_ON   = 2'd2,
        PLAYER_OFF  = 2'd3
    } player_state_t;

    typedef struct packed {
        logic [2:0] color;
        logic [3:0] count;
    } led_evt_t;

    // Status-layer colour; unknown codes leave LED0 dark.
    function automatic logic [2:0] status_color(input logic [31:0] code);
        logic [2:0] color;
        color = COLOR_OFF;
        case (code)
            IAGC_STATUS_INIT:     color = COLOR_RED;
            IAGC_STATUS_IDLE:     color = COLOR_GREEN;
            IAGC_STATUS_SAMPLE:   color = COLOR_BLUE;
            IAGC_STATUS_DUMP_MEM: color = COLOR_YELLOW;
            IAGC_STATUS_HALT:     color = COLOR_MAGENTA;
            default:              color = COLOR_OFF;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/pmod_led_scheduler_fifo.sv
// Small first-word-fall-through event queue; dout always shows the oldest entry.
module led_evt_fifo
    import pmod_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     i_clock,
    input  logic     i_reset,
    input  logic     push,
    input  logic     pop,
    input  led_evt_t din,
    output led_evt_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    led_evt_t    mem [FIFO_DEPTH];

    always_ff @(posedge i_clock) begin
        if (push && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // Extra pointer MSB separates the wrapped-full case from empty.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign dout  = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/pmod_led_scheduler.sv
// Drives the two PMOD RGB LEDs: LED0 shows IAGC status, LED1 plays queued blink events.
module pmod_led_scheduler
    import pmod_pkg::*;
#(
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int PWM_PERIOD       = 50,
    parameter int BLINK_TICKS      = 25000000,
    parameter int FIFO_DEPTH       = 4,
    parameter int ERR_BLINKS       = 3
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
    input  logic                        i_evt_valid,
    input  logic [2:0]                  i_evt_color,
    input  logic [3:0]                  i_evt_count,
    output logic                        o_evt_ready,
    output logic                        o_led0_r,
    output logic                        o_led0_g,
    output logic                        o_led0_b,
    output logic                        o_led1_r,
    output logic                        o_led1_g,
    output logic                        o_led1_b,
    output logic                        o_busy
);

    localparam int PWM_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int TICK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PWM_W-1:0]  PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BLINK_TICKS - 1);

    logic [PWM_W-1:0]            pwm_cnt_reg;
    logic                        pwm;
    logic [IAGC_STATUS_SIZE-1:0] status_d_reg;
    logic                        auto_evt;

    logic     fifo_push;
    logic     fifo_pop;
    led_evt_t fifo_din;
    led_evt_t fifo_dout;
    logic     fifo_full;
    logic     fifo_empty;

    player_state_t     state_reg;
    logic [TICK_W-1:0] tick_reg;
    logic [3:0]        rem_reg;
    led_evt_t          pending_reg;
    logic [2:0]        color_reg;
    logic [2:0]        led0_reg;
    logic [2:0]        led1_reg;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pwm_cnt_reg  <= '0;
            status_d_reg <= '0;
        end else begin
            pwm_cnt_reg  <= (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + PWM_W'(1);
            status_d_reg <= i_iagc_status;
        end
    end

    assign pwm = (pwm_cnt_reg == PWM_LAST);

    // Entry into CMD_ERROR raises one internal event and takes the queue slot this cycle.
    assign auto_evt = (i_iagc_status == IAGC_STATUS_SIZE'(IAGC_STATUS_CMD_ERROR)) &&
                      (status_d_reg  != IAGC_STATUS_SIZE'(IAGC_STATUS_CMD_ERROR));

    assign o_evt_ready = !i_reset && !fifo_full && !auto_evt;
    assign fifo_push   = (auto_evt && !fifo_full && !i_reset) || (i_evt_valid && o_evt_ready);
    assign fifo_din    = auto_evt ? led_evt_t'({COLOR_RED, 4'(ERR_BLINKS)})
                                  : led_evt_t'({i_evt_color, i_evt_count});
    assign fifo_pop    = (state_reg == PLAYER_IDLE) && !fifo_empty;

    led_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg   <= PLAYER_IDLE;
            tick_reg    <= '0;
            rem_reg     <= '0;
            pending_reg <= '0;
            color_reg   <= COLOR_OFF;
            led0_reg    <= COLOR_OFF;
            led1_reg    <= COLOR_OFF;
        end else begin
            led0_reg <= status_color(32'(i_iagc_status)) & {3{pwm}};
            led1_reg <= (state_reg == PLAYER_ON) ? (color_reg & {3{pwm}}) : COLOR_OFF;
            case (state_reg)
                PLAYER_IDLE: begin
                    // The head word is captured as it is popped; LOAD consumes it next cycle.
                    if (!fifo_empty) begin
                        pending_reg <= fifo_dout;
                        state_reg   <= PLAYER_LOAD;
                    end
                end
                PLAYER_LOAD: begin
                    color_reg <= pending_reg.color;
                    rem_reg   <= (pending_reg.count == 4'd0) ? 4'd1 : pending_reg.count;
                    tick_reg  <= '0;
                    state_reg <= PLAYER_ON;
                end
                PLAYER_ON: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_reg  <= '0;
                        state_reg <= PLAYER_OFF;
                    end else begin
                        tick_reg <= tick_reg + TICK_W'(1);
                    end
                end
                PLAYER_OFF: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_reg  <= '0;
                        rem_reg   <= rem_reg - 4'd1;
                        state_reg <= (rem_reg == 4'd1) ? PLAYER_IDLE : PLAYER_ON;
                    end else begin
                        tick_reg <= tick_reg + TICK_W'(1);
                    end
                end
                default: state_reg <= PLAYER_IDLE;
            endcase
        end
    end

    assign {o_led0_r, o_led0_g, o_led0_b} = led0_reg;
    assign {o_led1_r, o_led1_g, o_led1_b} = led1_reg;
    assign o_busy = !i_reset && ((state_reg != PLAYER_IDLE) || !fifo_empty);

endmodule

// File: tb/tb_pmod_led_scheduler.sv
// Self-checking bench: per-cycle timeline reference model plus directed corner-case sequences.
module tb_pmod_led_scheduler;
    import pmod_pkg::*;

    localparam int P  = 4;
    localparam int BT = 8;
    localparam int D  = 4;
    localparam int EB = 3;

    logic       clk;
    logic       rst;
    logic [3:0] st;
    logic       v;
    logic [2:0] col;
    logic [3:0] ecnt;
    logic       ready, busy;
    logic       l0r, l0g, l0b, l1r, l1g, l1b;

    pmod_led_scheduler #(
        .IAGC_STATUS_SIZE (4),
        .PWM_PERIOD       (P),
        .BLINK_TICKS      (BT),
        .FIFO_DEPTH       (D),
        .ERR_BLINKS       (EB)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_iagc_status (st),
        .i_evt_valid   (v),
        .i_evt_color   (col),
        .i_evt_count   (ecnt),
        .o_evt_ready   (ready),
        .o_led0_r      (l0r),
        .o_led0_g      (l0g),
        .o_led0_b      (l0b),
        .o_led1_r      (l1r),
        .o_led1_g      (l1g),
        .o_led1_b      (l1b),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: event queue plus the start cycle of the event being played.
    typedef struct {
        logic [2:0] color;
        logic [3:0] count;
    } evt_t;
    evt_t       mq[$];
    bit         m_active;
    longint     m_pop;
    logic [2:0] m_color;
    int         m_n;
    longint     m_pwm_base;
    logic [3:0] m_prev;
    logic [2:0] m_led0, m_led1;
    longint     cyc = 0;

    // Observations of the most recent step, and counters for directed sequences.
    logic       obs_ready, obs_busy;
    logic [2:0] obs_l0, obs_l1;
    int         l0_cnt[3];
    int         l1_cnt[3];
    int         acc_cnt;
    logic [2:0] order[$];
    logic [2:0] last_col;
    bit         verbose;
    logic [3:0] cur_st;

    typedef struct {
        logic [3:0] status;
        logic [2:0] exp_color;
    } dec_vec_t;
    dec_vec_t tbl[8];

    function automatic logic [2:0] dec(input logic [3:0] s);
        case (s)
            4'd1:    return 3'b100;
            4'd2:    return 3'b010;
            4'd3:    return 3'b001;
            4'd7:    return 3'b110;
            4'd11:   return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit m_playing(input longint c);
        return m_active && (c < m_pop + 2 + 2 * BT * m_n);
    endfunction

    function automatic bit m_on(input longint c);
        longint d;
        if (!m_active) return 1'b0;
        d = c - m_pop - 2;
        return (d >= 0) && (d < 2 * BT * m_n) && ((d % (2 * BT)) < BT);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 3; i++) begin
            l0_cnt[i] = 0;
            l1_cnt[i] = 0;
        end
        acc_cnt  = 0;
        order    = {};
        last_col = 3'b000;
    endtask

    task automatic step(input bit r, input logic [3:0] s, input bit vv,
                        input logic [2:0] c, input logic [3:0] n);
        bit   auto_e, exp_ready, pwm_m, idle;
        int   sz;
        evt_t e;
        rst = r; st = s; v = vv; col = c; ecnt = n;
        #1;
        auto_e    = !r && (s == 4'd6) && (m_prev != 4'd6);
        exp_ready = !r && (mq.size() < D) && !auto_e;
        obs_ready = ready;
        obs_busy  = busy;
        obs_l0    = {l0r, l0g, l0b};
        obs_l1    = {l1r, l1g, l1b};
        chk("ready", int'(obs_ready), int'(exp_ready));
        if (!r) begin
            chk("led0", int'(obs_l0), int'(m_led0));
            chk("led1", int'(obs_l1), int'(m_led1));
            chk("busy", int'(obs_busy), int'(m_playing(cyc) || (mq.size() > 0)));
            for (int i = 0; i < 3; i++) begin
                l0_cnt[i] += int'(obs_l0[i]);
                l1_cnt[i] += int'(obs_l1[i]);
            end
            if (obs_l1 != 3'b000 && obs_l1 != last_col) begin
                order.push_back(obs_l1);
                last_col = obs_l1;
            end
            if (vv && obs_ready) begin
                acc_cnt++;
                if (verbose) $display("txn push color=%b count=%0d cycle=%0d", c, n, cyc);
            end
        end
        // Advance the model across the clock edge.
        if (r) begin
            mq = {};
            m_active   = 1'b0;
            m_prev     = 4'd0;
            m_led0     = 3'b000;
            m_led1     = 3'b000;
            m_pwm_base = cyc + 1;
        end else begin
            pwm_m  = ((cyc - m_pwm_base) % P) == P - 1;
            m_led0 = dec(s) & {3{pwm_m}};
            m_led1 = m_on(cyc) ? (m_color & {3{pwm_m}}) : 3'b000;
            idle   = !m_playing(cyc);
            sz     = mq.size();
            if (idle && sz > 0) begin
                e        = mq.pop_front();
                m_active = 1'b1;
                m_pop    = cyc;
                m_color  = e.color;
                m_n      = (e.count == 4'd0) ? 1 : int'(e.count);
            end
            if (auto_e) begin
                if (sz < D) mq.push_back('{color: 3'b100, count: 4'(EB)});
            end else if (vv && sz < D) begin
                mq.push_back('{color: c, count: n});
            end
            m_prev = s;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(1'b0, cur_st, 1'b0, 3'b000, 4'd0);
    endtask

    // Returns the step index at which o_busy was first seen low, or -1 on timeout.
    task automatic run_until_idle(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            step(1'b0, cur_st, 1'b0, 3'b000, 4'd0);
            if (!obs_busy) begin
                k = i;
                break;
            end
        end
        chk("idle_timeout", int'(k > 0), 1);
    endtask

    initial begin
        int         k;
        logic [2:0] acc;
        logic [2:0] exp_order[5];
        logic [3:0] rst_choices[8];

        tbl[0] = '{4'd0,  3'b000};
        tbl[1] = '{4'd1,  3'b100};
        tbl[2] = '{4'd2,  3'b010};
        tbl[3] = '{4'd3,  3'b001};
        tbl[4] = '{4'd7,  3'b110};
        tbl[5] = '{4'd11, 3'b101};
        tbl[6] = '{4'd5,  3'b000};
        tbl[7] = '{4'd15, 3'b000};
        exp_order[0] = 3'b100;
        exp_order[1] = 3'b010;
        exp_order[2] = 3'b001;
        exp_order[3] = 3'b110;
        exp_order[4] = 3'b101;
        rst_choices[0] = 4'd1; rst_choices[1] = 4'd2;  rst_choices[2] = 4'd3; rst_choices[3] = 4'd6;
        rst_choices[4] = 4'd7; rst_choices[5] = 4'd11; rst_choices[6] = 4'd0; rst_choices[7] = 4'd5;
        verbose = 1'b1;
        m_prev = 4'd0;
        m_led0 = 3'b000;
        m_led1 = 3'b000;
        m_active = 1'b0;
        m_pwm_base = 0;
        clr_counts();

        // 1: reset then IDLE status, green strobe once per PWM period.
        step(1'b1, 4'd2, 1'b0, 3'b000, 4'd0);
        step(1'b1, 4'd2, 1'b0, 3'b000, 4'd0);
        cur_st = 4'd2;
        clr_counts();
        idle_steps(13);
        chk("t1_led0_g_pulses", l0_cnt[1], 3);
        chk("t1_led0_r_pulses", l0_cnt[2], 0);
        chk("t1_led0_b_pulses", l0_cnt[0], 0);
        chk("t1_led1_pulses", l1_cnt[0] + l1_cnt[1] + l1_cnt[2], 0);
        chk("t1_busy", int'(obs_busy), 0);

        // Status decode table: one PWM period per code, OR of LED0 over that period.
        foreach (tbl[t]) begin
            cur_st = tbl[t].status;
            acc = 3'b000;
            for (int i = 0; i < 5; i++) begin
                step(1'b0, cur_st, 1'b0, 3'b000, 4'd0);
                if (i > 0) acc |= obs_l0;
            end
            chk($sformatf("decode_status_%0d", tbl[t].status), int'(acc), int'(tbl[t].exp_color));
        end

        // 2: one green event of two blinks.
        cur_st = 4'd3;
        clr_counts();
        step(1'b0, cur_st, 1'b1, 3'b010, 4'd2);
        run_until_idle(200, k);
        chk("t2_led1_g_pulses", l1_cnt[1], 4);
        chk("t2_busy_fall", k, 35);

        // 3: entry into CMD_ERROR; concurrent external push refused.
        cur_st = 4'd2;
        idle_steps(2);
        clr_counts();
        cur_st = 4'd6;
        step(1'b0, cur_st, 1'b1, 3'b010, 4'd1);
        chk("t3_ready_on_edge", int'(obs_ready), 0);
        run_until_idle(200, k);
        chk("t3_red_pulses", l1_cnt[2], 6);
        chk("t3_green_pulses", l1_cnt[1], 0);

        // 4: six back-to-back pushes; five fit, then ready drops; order preserved.
        cur_st = 4'd2;
        idle_steps(2);
        clr_counts();
        for (int i = 0; i < 5; i++) step(1'b0, cur_st, 1'b1, exp_order[i], 4'd1);
        step(1'b0, cur_st, 1'b1, 3'b011, 4'd1);
        chk("t4_ready_when_full", int'(obs_ready), 0);
        chk("t4_accepted", acc_cnt, 5);
        run_until_idle(400, k);
        chk("t4_order_len", order.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t4_order_%0d", i), (i < order.size()) ? int'(order[i]) : -1,
                int'(exp_order[i]));

        // 5: count 0 plays a single blink.
        clr_counts();
        step(1'b0, cur_st, 1'b1, 3'b001, 4'd0);
        run_until_idle(200, k);
        chk("t5_led1_b_pulses", l1_cnt[0], 2);
        chk("t5_busy_fall", k, 19);

        // 6: reset mid-ON with two events queued.
        step(1'b0, cur_st, 1'b1, 3'b010, 4'd3);
        step(1'b0, cur_st, 1'b1, 3'b001, 4'd2);
        step(1'b0, cur_st, 1'b1, 3'b100, 4'd2);
        idle_steps(3);
        step(1'b1, cur_st, 1'b0, 3'b000, 4'd0);
        clr_counts();
        step(1'b0, cur_st, 1'b0, 3'b000, 4'd0);
        chk("t6_leds_after_reset", int'({obs_l0, obs_l1}), 0);
        chk("t6_busy_after_reset", int'(obs_busy), 0);
        idle_steps(40);
        chk("t6_no_playback", l1_cnt[0] + l1_cnt[1] + l1_cnt[2], 0);

        // Randomised traffic against the model.
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) cur_st = rst_choices[$urandom_range(0, 7)];
            step(($urandom_range(0, 199) == 0), cur_st, ($urandom_range(0, 5) == 0),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
